// File: rtl/arp_rewrite.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | arp_rewrite : next-hop ARP resolution and L2/L3 header rewrite stage     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

module arp_rewrite #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              arp_lookup,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     nh_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     oq_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     arp_miss_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ttl_expired_count,
  input  logic                              tbl_rd_req,
  input  logic                              tbl_wr_req,
  input  logic [4:0]                        tbl_rd_addr,
  input  logic [4:0]                        tbl_wr_addr,
  input  logic [79:0]                       tbl_wr_data,
  output logic [79:0]                       tbl_rd_data,
  output logic                              tbl_rd_ack,
  output logic                              tbl_wr_ack
);

  localparam int         c_TBL_DEPTH  = 32;
  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_LOOKUP  = 2'd1;
  localparam logic [1:0] c_ST_HDR     = 2'd2;
  localparam logic [1:0] c_ST_BODY    = 2'd3;

  logic [47:0] mac_tbl_q [c_TBL_DEPTH];
  logic [31:0] ip_tbl_q  [c_TBL_DEPTH];
  logic [79:0] rd_data_q;
  logic        rd_ack_q;
  logic        wr_ack_q;

  logic [1:0]                         state_q, state_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]     data_q;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   strb_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]    user_q;
  logic                               last_q;
  logic                               lookup_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]      nh_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]      oq_q;
  logic                               hit_q;
  logic [47:0]                        mac_q;
  logic [7:0]                         ttl_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]      miss_cnt_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]      ttl_cnt_q;

  logic [c_TBL_DEPTH-1:0]             w_match;
  logic                               w_hit;
  logic [4:0]                         w_idx;
  logic                               w_oq_ok;
  logic [7:0]                         w_oq_dst;
  logic [7:0]                         w_src;
  logic [7:0]                         w_cpu_dst;
  logic                               w_ttl_exp;
  logic                               w_miss;
  logic                               w_rewrite;
  logic [16:0]                        w_csum_sum;
  logic [15:0]                        w_csum_new;
  logic [C_S_AXIS_DATA_WIDTH-1:0]     w_hdr_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]    w_hdr_user;
  logic                               w_hdr_done;

  // ARP table: contents survive reset; reads see the pre-write value on a collision
  always_ff @(posedge AXI_ACLK) begin
    if (tbl_wr_req) begin
      mac_tbl_q[tbl_wr_addr] <= tbl_wr_data[79:32];
      ip_tbl_q[tbl_wr_addr]  <= tbl_wr_data[31:0];
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      rd_ack_q <= tbl_rd_req;
      wr_ack_q <= tbl_wr_req;
      if (tbl_rd_req) begin
        rd_data_q <= {mac_tbl_q[tbl_rd_addr], ip_tbl_q[tbl_rd_addr]};
      end
    end
  end

  assign tbl_rd_data = rd_data_q;
  assign tbl_rd_ack  = rd_ack_q;
  assign tbl_wr_ack  = wr_ack_q;

  for (genvar gi = 0; gi < c_TBL_DEPTH; gi++) begin : g_match
    assign w_match[gi] = (ip_tbl_q[gi] != 32'd0) && (ip_tbl_q[gi] == nh_q);
  end

  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    w_hit = 1'b0;
    w_idx = 5'd0;
    for (int i = c_TBL_DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = 5'(i);
      end
    end
  end

  always_comb begin
    w_oq_ok  = 1'b1;
    w_oq_dst = 8'h00;
    case (oq_q)
      32'd0:   w_oq_dst = 8'h01;
      32'd1:   w_oq_dst = 8'h04;
      32'd2:   w_oq_dst = 8'h10;
      32'd3:   w_oq_dst = 8'h40;
      32'd4:   w_oq_dst = 8'h02;
      default: w_oq_ok  = 1'b0;
    endcase
  end

  assign w_src      = user_q[SRC_PORT_POS +: 8];
  assign w_cpu_dst  = {w_src[6], 1'b0, w_src[4], 1'b0, w_src[2], 1'b0, w_src[0], 1'b0};
  assign w_ttl_exp  = lookup_q && (ttl_q <= 8'd1);
  assign w_miss     = lookup_q && !w_ttl_exp && !(hit_q && w_oq_ok);
  assign w_rewrite  = lookup_q && !w_ttl_exp && hit_q && w_oq_ok;
  assign w_csum_sum = {1'b0, data_q[63:48]} + 17'h00100;
  assign w_csum_new = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};

  always_comb begin
    w_hdr_data = data_q;
    w_hdr_user = user_q;
    if (w_rewrite) begin
      w_hdr_data[C_S_AXIS_DATA_WIDTH-1 -: 48] = mac_q;
      w_hdr_data[79:72]                       = ttl_q - 8'd1;
      w_hdr_data[63:48]                       = w_csum_new;
      w_hdr_user[DST_PORT_POS +: 8]           = w_oq_dst;
    end else if (w_ttl_exp || w_miss) begin
      w_hdr_user[DST_PORT_POS +: 8] = w_cpu_dst;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the state register says
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TUSER  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    if (!AXI_RESET) begin
      case (state_q)
        c_ST_IDLE: S_AXIS_TREADY = 1'b1;
        c_ST_HDR: begin
          M_AXIS_TDATA  = w_hdr_data;
          M_AXIS_TSTRB  = strb_q;
          M_AXIS_TUSER  = w_hdr_user;
          M_AXIS_TVALID = 1'b1;
          M_AXIS_TLAST  = last_q;
        end
        c_ST_BODY: begin
          M_AXIS_TDATA  = S_AXIS_TDATA;
          M_AXIS_TSTRB  = S_AXIS_TSTRB;
          M_AXIS_TUSER  = S_AXIS_TUSER;
          M_AXIS_TVALID = S_AXIS_TVALID;
          M_AXIS_TLAST  = S_AXIS_TLAST;
          S_AXIS_TREADY = M_AXIS_TREADY;
        end
        default: S_AXIS_TREADY = 1'b0;
      endcase
    end
  end

  assign w_hdr_done = (state_q == c_ST_HDR) && M_AXIS_TREADY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:   if (S_AXIS_TVALID) state_d = c_ST_LOOKUP;
      c_ST_LOOKUP: state_d = c_ST_HDR;
      c_ST_HDR:    if (M_AXIS_TREADY) state_d = last_q ? c_ST_IDLE : c_ST_BODY;
      c_ST_BODY:   if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state_d = c_ST_IDLE;
      default:     state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESET && (state_q == c_ST_IDLE) && S_AXIS_TVALID) begin
      data_q   <= S_AXIS_TDATA;
      strb_q   <= S_AXIS_TSTRB;
      user_q   <= S_AXIS_TUSER;
      last_q   <= S_AXIS_TLAST;
      lookup_q <= arp_lookup;
      nh_q     <= nh_reg;
      oq_q     <= oq_reg;
    end
    if (state_q == c_ST_LOOKUP) begin
      hit_q <= w_hit;
      mac_q <= mac_tbl_q[w_idx];
      ttl_q <= data_q[79:72];
    end
  end

  // Counter clear has priority over a same-cycle increment
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET || (reset == 32'd1)) begin
      miss_cnt_q <= '0;
      ttl_cnt_q  <= '0;
    end else if (w_hdr_done) begin
      if (w_miss)    miss_cnt_q <= miss_cnt_q + 1'b1;
      if (w_ttl_exp) ttl_cnt_q  <= ttl_cnt_q + 1'b1;
    end
  end

  assign arp_miss_count    = miss_cnt_q;
  assign ttl_expired_count = ttl_cnt_q;

endmodule

`default_nettype wire
